input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 4, meaning the number of consecutive synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in, input, 1 bit: raw, asynchronous, bouncy level.
REQ-005 The block SHALL have port en, input, 1 bit: qualify enable; 0 freezes the debounce FSM and counter.
REQ-006 The block SHALL have port d_out, output, 1 bit: debounced level.
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse when d_out goes 0->1.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse when d_out goes 1->0.
REQ-009 The block SHALL have port chg, output, 1 bit: rise OR fall, registered; this is the capture enable for the downstream enable flop.

Function
REQ-010 The block SHALL pass in through a 2-flop synchronizer (sync1, sync2); sync2 is the only signal the FSM samples; the synchronizer SHALL run regardless of en.
REQ-011 The FSM SHALL have four states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-012 STABLE_LOW with sync2=1 SHALL go to PEND_HIGH with cnt=1; STABLE_HIGH with sync2=0 SHALL go to PEND_LOW with cnt=1.
REQ-013 PEND_HIGH with sync2=0 SHALL return to STABLE_LOW with cnt=0 and no output change (glitch rejected); PEND_LOW with sync2=1 likewise returns to STABLE_HIGH.
REQ-014 In PEND_x with sync2 still at the new level and cnt<CNT_MAX-1, cnt SHALL increment by 1.
REQ-015 In PEND_x with sync2 at the new level and cnt==CNT_MAX-1, the block SHALL commit: enter STABLE_x, cnt=0, update d_out, and pulse rise/fall and chg on the same edge.
REQ-016 Latency: with en=1 and in stable, d_out SHALL change on the (CNT_MAX+2)th consecutive rising edge that samples in at the new level (2 sync edges + CNT_MAX counted samples).
REQ-017 rise, fall and chg SHALL be high for exactly one cycle per commit; rise and fall SHALL never be high together.
REQ-018 While en=0, state, cnt and d_out SHALL hold and rise/fall/chg SHALL be 0; on en returning to 1, evaluation resumes from the held state and cnt.
REQ-019 A commit SHALL occur only on an edge with en=1; a PEND state that would reach the commit condition with en=0 SHALL wait.
REQ-020 cnt SHALL be $clog2(CNT_MAX) bits wide, SHALL never exceed CNT_MAX-1, and SHALL never wrap.
REQ-021 All outputs SHALL be driven directly from flops, with no combinational path from in or en to any output.

Reset
REQ-022 While reset_n=0, the block SHALL hold sync1=sync2=0, state=STABLE_LOW, cnt=0, d_out=0, rise=fall=chg=0, independent of clk.
REQ-023 Reset asserted mid-PEND SHALL discard the partial count; after release, a high in needs the full CNT_MAX+2 edges again.
REQ-024 After reset_n deasserts, the first state update SHALL occur on the next rising edge of clk.

Verification
REQ-025 The bench SHALL check clean rise: with CNT_MAX=4 and en=1, in 0->1 held stable -> d_out=1, rise=1 and chg=1 on the 6th edge, then rise=0 on the next edge.
REQ-026 The bench SHALL check glitch rejection: in high for 3 edges, then low -> d_out stays 0 and rise/chg are never asserted.
REQ-027 The bench SHALL check the falling path: starting from d_out=1, in 1->0 held -> d_out=0, fall=1 for exactly one cycle on the 6th edge.
REQ-028 The bench SHALL check freeze: in high, en dropped to 0 after 4 edges for 10 cycles, then raised -> no commit while en=0; commit 2 edges after en returns to 1.
REQ-029 The bench SHALL check async reset: reset_n pulsed low between clock edges during PEND_HIGH -> all outputs 0 immediately; the full 6-edge latency is restored after release.
REQ-030 The bench SHALL check bounce: in toggled every cycle for 50 cycles, then held high -> exactly one rise pulse, 6 edges after the final hold begins.

Source files
------------

// File: rtl/input_debouncer.sv
// ============================================================================
// Module   : input_debouncer
// Purpose  : 2-flop synchronizer plus counting debounce FSM with edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer #(
   parameter int CNT_MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   input  logic en,
   output logic d_out,
   output logic rise,
   output logic fall,
   output logic chg
);

   localparam int                CNT_W    = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } state_t;

   logic             sync1_q, sync2_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_out_q, d_out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             chg_q, chg_d;

   // Synchronizer runs every cycle so the FSM resumes on a current sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         d_out_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         chg_q   <= chg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_out_d = d_out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (en) begin
         case (state_q)
            STABLE_LOW: begin
               if (sync2_q) begin
                  state_d = PEND_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
            PEND_HIGH: begin
               if (!sync2_q) begin
                  state_d = STABLE_LOW;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_HIGH;
                  cnt_d   = '0;
                  d_out_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STABLE_HIGH: begin
               if (!sync2_q) begin
                  state_d = PEND_LOW;
                  cnt_d   = CNT_ONE;
               end
            end
            PEND_LOW: begin
               if (sync2_q) begin
                  state_d = STABLE_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_LOW;
                  cnt_d   = '0;
                  d_out_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end
         endcase
      end
      chg_d = rise_d | fall_d;
   end

   assign d_out = d_out_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign chg   = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Scoreboard bench for input_debouncer with CNT_MAX = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

   typedef struct {
      int   cyc;
      logic is_rise;
   } ev_t;

   logic clk;
   logic reset_n;
   logic in;
   logic en;
   logic d_out;
   logic rise;
   logic fall;
   logic chg;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  sb[$];
   ev_t  mon_ev;

   input_debouncer #(.CNT_MAX(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (in),
      .en      (en),
      .d_out   (d_out),
      .rise    (rise),
      .fall    (fall),
      .chg     (chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Every observed pulse must match the oldest expected commit.
   always @(negedge clk) begin
      checks++;
      if (chg !== (rise | fall)) begin
         errors++;
         $display("FAIL chg_vs_pulses: cyc %0d chg %b rise %b fall %b", cyc, chg, rise, fall);
      end
      checks++;
      if (rise === 1'b1 && fall === 1'b1) begin
         errors++;
         $display("FAIL rise_and_fall: cyc %0d both high", cyc);
      end
      if (rise === 1'b1 || fall === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: cyc %0d rise %b fall %b, expected none", cyc, rise, fall);
         end else begin
            mon_ev = sb.pop_front();
            if (mon_ev.cyc !== cyc || mon_ev.is_rise !== rise) begin
               errors++;
               $display("FAIL pulse_timing: got cyc %0d rise %b, expected cyc %0d rise %b",
                        cyc, rise, mon_ev.cyc, mon_ev.is_rise);
            end
         end
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      in      = 1'b0;
      en      = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      checks++;
      if ({d_out, rise, fall, chg} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async: got %b expected 0000", {d_out, rise, fall, chg});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({d_out, rise, fall, chg} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got %b expected 0000", {d_out, rise, fall, chg});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clean_rise();
      int c0;
      @(negedge clk);
      c0 = cyc;
      in = 1'b1;
      sb.push_back('{c0 + 6, 1'b1});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_out !== (cyc >= c0 + 6)) begin
            errors++;
            $display("FAIL rise_d_out: edge %0d got %b expected %b", k, d_out, (cyc >= c0 + 6));
         end
         checks++;
         if (rise !== (cyc == c0 + 6)) begin
            errors++;
            $display("FAIL rise_pulse: edge %0d got %b expected %b", k, rise, (cyc == c0 + 6));
         end
      end
      drain(10);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rise_missing: %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_fall();
      int c0;
      @(negedge clk);
      c0 = cyc;
      in = 1'b0;
      sb.push_back('{c0 + 6, 1'b0});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_out !== (cyc < c0 + 6)) begin
            errors++;
            $display("FAIL fall_d_out: edge %0d got %b expected %b", k, d_out, (cyc < c0 + 6));
         end
         checks++;
         if (fall !== (cyc == c0 + 6)) begin
            errors++;
            $display("FAIL fall_pulse: edge %0d got %b expected %b", k, fall, (cyc == c0 + 6));
         end
      end
      drain(10);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL fall_missing: %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      @(negedge clk);
      in = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 3) in = 1'b0;
         #1;
         if (rise === 1'b1 || chg === 1'b1) pulses++;
         checks++;
         if (d_out !== 1'b0) begin
            errors++;
            $display("FAIL glitch_d_out: step %0d got %b expected 0", k, d_out);
         end
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL glitch_pulses: got %0d expected 0", pulses);
      end
   endtask

   task automatic test_freeze();
      int c1;
      @(negedge clk);
      in = 1'b1;
      repeat (4) @(negedge clk);
      en = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_out !== 1'b0 || rise !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: step %0d got d_out %b rise %b expected 0 0", k, d_out, rise);
         end
      end
      c1 = cyc;
      en = 1'b1;
      sb.push_back('{c1 + 2, 1'b1});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_out !== (cyc >= c1 + 2)) begin
            errors++;
            $display("FAIL freeze_resume: step %0d got %b expected %b", k, d_out, (cyc >= c1 + 2));
         end
      end
      drain(10);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL freeze_missing: %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      @(negedge clk);
      c0 = cyc;
      in = 1'b0;
      sb.push_back('{c0 + 6, 1'b0});
      drain(12);
      checks++;
      if (sb.size() != 0 || d_out !== 1'b0) begin
         errors++;
         $display("FAIL return_low: pending %0d d_out %b expected 0 0", sb.size(), d_out);
         sb.delete();
      end
      @(negedge clk);
      c0 = cyc;
      in = 1'b1;
      sb.push_back('{c0 + 6, 1'b1});
      drain(12);
      checks++;
      if (sb.size() != 0 || d_out !== 1'b1) begin
         errors++;
         $display("FAIL return_high: pending %0d d_out %b expected 0 1", sb.size(), d_out);
         sb.delete();
      end
      @(negedge clk);
      c0 = cyc;
      in = 1'b0;
      sb.push_back('{c0 + 6, 1'b0});
      drain(12);
      checks++;
      if (sb.size() != 0 || d_out !== 1'b0) begin
         errors++;
         $display("FAIL return_low2: pending %0d d_out %b expected 0 0", sb.size(), d_out);
         sb.delete();
      end
   endtask

   task automatic test_async_reset();
      int r;
      @(negedge clk);
      in = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({d_out, rise, fall, chg} !== 4'b0000) begin
         errors++;
         $display("FAIL areset_pend: got %b expected 0000", {d_out, rise, fall, chg});
      end
      @(negedge clk);
      @(negedge clk);
      r = cyc;
      reset_n = 1'b1;
      sb.push_back('{r + 6, 1'b1});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_out !== (cyc >= r + 6)) begin
            errors++;
            $display("FAIL areset_latency: edge %0d got %b expected %b", k, d_out, (cyc >= r + 6));
         end
      end
      drain(10);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (d_out !== 1'b0) begin
         errors++;
         $display("FAIL areset_high: got %b expected 0", d_out);
      end
      in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (d_out !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL areset_after: d_out %b pending %0d expected 0 0", d_out, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_bounce();
      int c0;
      int rises = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rise === 1'b1) rises++;
         in = ~in;
      end
      @(negedge clk);
      if (rise === 1'b1) rises++;
      c0 = cyc;
      in = 1'b1;
      sb.push_back('{c0 + 6, 1'b1});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         #1;
         if (rise === 1'b1) rises++;
         checks++;
         if (rise !== (cyc == c0 + 6)) begin
            errors++;
            $display("FAIL bounce_pulse: edge %0d got %b expected %b", k, rise, (cyc == c0 + 6));
         end
      end
      checks++;
      if (rises != 1 || d_out !== 1'b1) begin
         errors++;
         $display("FAIL bounce_count: rises %0d d_out %b expected 1 1", rises, d_out);
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_fall();
      test_glitch();
      test_freeze();
      test_back_to_back();
      test_async_reset();
      test_bounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
